// File: rtl/led_driver_if.sv
// Parallel-pattern / serial-LED bundle between a pattern source and led_driver.
interface led_driver_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] i_Data16;
  logic              o_LEDData;
  logic              o_LEDLatch;

  modport master (
    output i_Data16,
    input  o_LEDData,
    input  o_LEDLatch
  );

  modport slave (
    input  i_Data16,
    output o_LEDData,
    output o_LEDLatch
  );
endinterface

// File: rtl/led_driver.sv
// Serialises a parallel LED word MSB-first into a shift-register chain, then strobes the latch.
// Optional build macro LED_DRIVER_INVERT_EN inverts data bits and makes the idle data level 1.
module led_driver #(
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  led_driver_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

`ifdef LED_DRIVER_INVERT_EN
  localparam logic IDLE_BIT = 1'b1;
`else
  localparam logic IDLE_BIT = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shadow;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_led_data;
  logic              r_led_latch;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      r_state     <= S_LOAD;
      r_shadow    <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_led_data  <= IDLE_BIT;
      r_led_latch <= 1'b0;
    end else begin
      // NOTE: outputs default to idle each cycle so only the active state
      // needs to override them; no path leaves an output unassigned.
      r_led_data  <= IDLE_BIT;
      r_led_latch <= 1'b0;

      case (r_state)
        S_LOAD: begin
          r_shadow  <= bus.i_Data16;
          r_bit_cnt <= CNT_TOP;
          r_state   <= S_SHIFT;
        end

        S_SHIFT: begin
          r_led_data <= r_shadow[r_bit_cnt] ^ IDLE_BIT;
          if (r_bit_cnt == '0) begin
            r_state <= S_LATCH;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end

        S_LATCH: begin
          r_led_latch <= 1'b1;
          if (GAP_CYCLES == 0) begin
            r_state <= S_LOAD;
          end else begin
            r_gap_cnt <= GAP_TOP;
            r_state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_LOAD;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.o_LEDData  = r_led_data;
  assign bus.o_LEDLatch = r_led_latch;

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: reset idle, frame shape, period, data snapshot, mid-frame reset abort.
module tb_led_driver;

  localparam int DATA_W = 16;
  localparam int GAP    = 2;
  localparam int PERIOD = DATA_W + 2 + GAP;

`ifdef LED_DRIVER_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic i_CLK   = 1'b0;
  logic i_RESET = 1'b0;

  led_driver_if #(.DATA_W(DATA_W)) bus ();

  led_driver #(
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .bus     (bus)
  );

  always #5 i_CLK = ~i_CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Independent latch-pulse monitor: counts pulses and records their cycle numbers.
  int cyc        = 0;
  int latch_cnt  = 0;
  int last_latch = 0;
  int prev_latch = 0;

  always @(negedge i_CLK) begin
    cyc = cyc + 1;
    if (bus.o_LEDLatch === 1'b1) begin
      prev_latch = last_latch;
      last_latch = cyc;
      latch_cnt  = latch_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample just after the falling edge so the monitor has run.
  task automatic step();
    @(negedge i_CLK);
    #1;
  endtask

  // Checks cycles 1..PERIOD after a LOAD edge: data bits, latch pulse, gap, next LOAD.
  task automatic run_frame(input string tag, input logic [DATA_W-1:0] pat,
                           input int chg_at, input logic [DATA_W-1:0] chg_val);
    logic exp_d;
    logic exp_l;
    for (int c = 1; c <= PERIOD; c++) begin
      step();
      if (c <= DATA_W) begin
        exp_d = pat[DATA_W-c] ^ INV;
        exp_l = 1'b0;
      end else if (c == DATA_W + 1) begin
        exp_d = INV;
        exp_l = 1'b1;
      end else begin
        exp_d = INV;
        exp_l = 1'b0;
      end
      check($sformatf("%s c%0d {latch,data}", tag, c),
            {30'd0, bus.o_LEDLatch, bus.o_LEDData}, {30'd0, exp_l, exp_d});
      if (c == chg_at) bus.i_Data16 = chg_val;
    end
  endtask

  initial begin
    int latch_before;

    bus.i_Data16 = 16'h4886;
    i_RESET      = 1'b0;

    // Reset held low: outputs stay idle.
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("reset c%0d", i), {30'd0, bus.o_LEDLatch, bus.o_LEDData}, {30'd0, 1'b0, INV});
    end
    check("no latch in reset", latch_cnt, 0);

    // First edge with reset high is LOAD; outputs still idle there.
    i_RESET = 1'b1;
    step();
    check("first load", {30'd0, bus.o_LEDLatch, bus.o_LEDData}, {30'd0, 1'b0, INV});
    run_frame("frame1", 16'h4886, 0, '0);

    // Free run: four more identical frames, latch pulses PERIOD cycles apart.
    for (int f = 2; f <= 5; f++) begin
      run_frame($sformatf("frame%0d", f), 16'h4886, 0, '0);
      check($sformatf("latch spacing f%0d", f), last_latch - prev_latch, PERIOD);
    end
    check("latch count 5 frames", latch_cnt, 5);

    // Input change during SHIFT is ignored until the next LOAD.
    run_frame("chg_mid", 16'h4886, 5, 16'hFFFF);
    run_frame("ones", 16'hFFFF, 10, 16'h4886);

    // Reset at the 8th shifted bit aborts the frame without a latch pulse.
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("pre_abort c%0d data", c), {31'd0, bus.o_LEDData},
            {31'd0, logic'(bus.i_Data16[DATA_W-c] ^ INV)});
    end
    latch_before = latch_cnt;
    i_RESET = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("abort c%0d", i), {30'd0, bus.o_LEDLatch, bus.o_LEDData}, {30'd0, 1'b0, INV});
    end
    check("no latch after abort", latch_cnt, latch_before);

    i_RESET = 1'b1;
    step();
    check("restart load", {30'd0, bus.o_LEDLatch, bus.o_LEDData}, {30'd0, 1'b0, INV});
    run_frame("restart", 16'h4886, 0, '0);
    check("one latch after restart", latch_cnt, latch_before + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
